// File: rtl/snoop_responder.sv
// Snoop responder: accepts bus operations from other agents, looks the line up
// in the LLC tag/state array, returns NOHIT/HIT/HITM, writes back M data and updates MESI.
module snoop_responder #(
  parameter int ADR_BITS      = 32,
  parameter int SET_BITS      = 15,
  parameter int BYTE_OFF_BITS = 6,
  parameter int TAG_BITS      = ADR_BITS - SET_BITS - BYTE_OFF_BITS,
  parameter int LRU_BITS      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                snp_valid,
  output logic                snp_ready,
  input  logic [2:0]          snp_op,
  input  logic [ADR_BITS-1:0] snp_addr,
  output logic                lk_req,
  output logic [SET_BITS-1:0] lk_set,
  output logic [TAG_BITS-1:0] lk_tag,
  input  logic                lk_ack,
  input  logic                lk_hit,
  input  logic [LRU_BITS-1:0] lk_way,
  input  logic [1:0]          lk_state,
  output logic                rslt_valid,
  output logic [1:0]          rslt,
  output logic                wb_req,
  output logic [ADR_BITS-1:0] wb_addr,
  input  logic                wb_done,
  output logic                upd_valid,
  output logic [SET_BITS-1:0] upd_set,
  output logic [LRU_BITS-1:0] upd_way,
  output logic [1:0]          upd_state,
  output logic                proto_err
);

  localparam int LINE_BITS = ADR_BITS - BYTE_OFF_BITS;

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  localparam logic [1:0] ST_M = 2'd0;
  localparam logic [1:0] ST_E = 2'd1;
  localparam logic [1:0] ST_S = 2'd2;
  localparam logic [1:0] ST_I = 2'd3;

  localparam logic [1:0] RS_NOHIT = 2'd0;
  localparam logic [1:0] RS_HIT   = 2'd1;
  localparam logic [1:0] RS_HITM  = 2'd2;

  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, WB, UPD} fsm_t;

  fsm_t                 state_q, state_d;
  logic [2:0]           op_q;
  logic [LINE_BITS-1:0] line_q;
  logic                 hit_q;
  logic [LRU_BITS-1:0]  way_q;
  logic [1:0]           mesi_q;
  logic [1:0]           nxt_mesi_q;
  logic [1:0]           rslt_c;
  logic [1:0]           nxt_mesi_c;
  logic [SET_BITS-1:0]  set_c;
  logic [TAG_BITS-1:0]  tag_c;
  logic                 unused_addr_bits;

  function automatic logic [1:0] snoop_rslt(input logic [2:0] op, input logic hit,
                                            input logic [1:0] mesi);
    logic [1:0] r;
    r = RS_NOHIT;
    if (hit) begin
      case (op)
        OP_READ, OP_RWIM: r = (mesi == ST_M) ? RS_HITM : RS_HIT;
        OP_INV:           r = RS_HIT;
        default:          r = RS_NOHIT;
      endcase
    end
    return r;
  endfunction

  function automatic logic [1:0] next_mesi(input logic [2:0] op, input logic [1:0] mesi);
    logic [1:0] n;
    case (op)
      OP_READ:         n = ST_S;
      OP_RWIM, OP_INV: n = ST_I;
      default:         n = mesi;
    endcase
    return n;
  endfunction

  assign unused_addr_bits = ^snp_addr[BYTE_OFF_BITS-1:0];
  assign set_c      = line_q[SET_BITS-1:0];
  assign tag_c      = line_q[SET_BITS +: TAG_BITS];
  assign rslt_c     = snoop_rslt(op_q, hit_q, mesi_q);
  assign nxt_mesi_c = next_mesi(op_q, mesi_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      line_q     <= '0;
      hit_q      <= 1'b0;
      way_q      <= '0;
      mesi_q     <= ST_I;
      nxt_mesi_q <= ST_I;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && snp_valid) begin
        op_q   <= snp_op;
        line_q <= snp_addr[ADR_BITS-1:BYTE_OFF_BITS];
        hit_q  <= 1'b0;
      end
      // A hit reporting state I is a stale tag and counts as a miss.
      if (state_q == LOOKUP && lk_ack) begin
        hit_q  <= lk_hit && (lk_state != ST_I);
        way_q  <= lk_way;
        mesi_q <= lk_state;
      end
      if (state_q == RESP) nxt_mesi_q <= nxt_mesi_c;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (snp_valid) begin
          case (snp_op)
            OP_READ, OP_INV, OP_RWIM: state_d = LOOKUP;
            OP_WRITE:                 state_d = RESP;
            default:                  state_d = IDLE;
          endcase
        end
      end
      LOOKUP: if (lk_ack) state_d = RESP;
      RESP: begin
        if (rslt_c == RS_HITM)                   state_d = WB;
        else if (hit_q && nxt_mesi_c != mesi_q)  state_d = UPD;
        else                                     state_d = IDLE;
      end
      WB:      if (wb_done) state_d = UPD;
      UPD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only from state and registered snoop context.
  always_comb begin
    snp_ready  = (state_q == IDLE);
    lk_req     = (state_q == LOOKUP);
    lk_set     = lk_req ? set_c : '0;
    lk_tag     = lk_req ? tag_c : '0;
    rslt_valid = (state_q == RESP);
    rslt       = rslt_valid ? rslt_c : RS_NOHIT;
    proto_err  = rslt_valid && (op_q == OP_INV) && hit_q &&
                 (mesi_q == ST_M || mesi_q == ST_E);
    wb_req     = (state_q == WB);
    wb_addr    = wb_req ? {tag_c, set_c, {BYTE_OFF_BITS{1'b0}}} : '0;
    upd_valid  = (state_q == UPD);
    upd_set    = upd_valid ? set_c : '0;
    upd_way    = upd_valid ? way_q : '0;
    upd_state  = upd_valid ? nxt_mesi_q : 2'd0;
  end

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder: cycle-exact checks of lookup, response,
// writeback, update and reset behaviour against hand-computed values.
module tb_snoop_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snp_valid;
  logic        snp_ready;
  logic [2:0]  snp_op;
  logic [31:0] snp_addr;
  logic        lk_req;
  logic [14:0] lk_set;
  logic [10:0] lk_tag;
  logic        lk_ack;
  logic        lk_hit;
  logic [2:0]  lk_way;
  logic [1:0]  lk_state;
  logic        rslt_valid;
  logic [1:0]  rslt;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic        wb_done;
  logic        upd_valid;
  logic [14:0] upd_set;
  logic [2:0]  upd_way;
  logic [1:0]  upd_state;
  logic        proto_err;
  logic [84:0] others;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign others = {lk_req, lk_set, lk_tag, rslt_valid, rslt, wb_req, wb_addr,
                   upd_valid, upd_set, upd_way, upd_state, proto_err};

  snoop_responder dut (
    .clk(clk), .rst_n(rst_n),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .lk_req(lk_req), .lk_set(lk_set), .lk_tag(lk_tag), .lk_ack(lk_ack),
    .lk_hit(lk_hit), .lk_way(lk_way), .lk_state(lk_state),
    .rslt_valid(rslt_valid), .rslt(rslt),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_done(wb_done),
    .upd_valid(upd_valid), .upd_set(upd_set), .upd_way(upd_way), .upd_state(upd_state),
    .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a snoop for one edge; returns in cycle T+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr);
    snp_valid = 1'b1;
    snp_op    = op;
    snp_addr  = addr;
    tick();
    snp_valid = 1'b0;
    snp_op    = 3'd0;
    snp_addr  = 32'h0;
  endtask

  task automatic set_lookup(input logic ack, input logic hit, input logic [2:0] way,
                            input logic [1:0] st);
    lk_ack   = ack;
    lk_hit   = hit;
    lk_way   = way;
    lk_state = st;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (snp_ready !== 1'b1 || others !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: ready=%b others=%h required ready=1 others=0",
                 i, snp_ready, others);
      end
      tick();
    end
  endtask

  task automatic test_read_hit_e();
    set_lookup(1'b1, 1'b1, 3'd5, 2'd1);
    issue(3'd1, 32'h0040_1240);
    checks++;
    if (lk_req !== 1'b1 || lk_set !== 15'h0049 || lk_tag !== 11'h002 || snp_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_lookup: req=%b set=%h tag=%h ready=%b required 1/0049/002/0",
               lk_req, lk_set, lk_tag, snp_ready);
    end
    tick();
    checks++;
    if (rslt_valid !== 1'b1 || rslt !== 2'd1 || wb_req !== 1'b0) begin
      errors++;
      $display("FAIL read_rslt: vld=%b rslt=%0d wb=%b required 1/1/0", rslt_valid, rslt, wb_req);
    end
    tick();
    checks++;
    if (upd_valid !== 1'b1 || upd_set !== 15'h0049 || upd_way !== 3'd5 ||
        upd_state !== 2'd2 || rslt_valid !== 1'b0 || wb_req !== 1'b0) begin
      errors++;
      $display("FAIL read_upd: vld=%b set=%h way=%0d st=%0d rv=%b wb=%b required 1/0049/5/2/0/0",
               upd_valid, upd_set, upd_way, upd_state, rslt_valid, wb_req);
    end
    tick();
    checks++;
    if (snp_ready !== 1'b1 || upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_done: ready=%b upd=%b required 1/0", snp_ready, upd_valid);
    end
  endtask

  task automatic test_read_hit_s();
    set_lookup(1'b1, 1'b1, 3'd3, 2'd2);
    issue(3'd1, 32'h0000_1000);
    tick();
    checks++;
    if (rslt_valid !== 1'b1 || rslt !== 2'd1) begin
      errors++;
      $display("FAIL read_s_rslt: vld=%b rslt=%0d required 1/1", rslt_valid, rslt);
    end
    tick();
    checks++;
    if (snp_ready !== 1'b1 || upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_s_done: ready=%b upd=%b required 1/0", snp_ready, upd_valid);
    end
  endtask

  task automatic test_read_stale_i();
    set_lookup(1'b1, 1'b1, 3'd4, 2'd3);
    issue(3'd1, 32'h0000_2000);
    tick();
    checks++;
    if (rslt_valid !== 1'b1 || rslt !== 2'd0) begin
      errors++;
      $display("FAIL read_i_rslt: vld=%b rslt=%0d required 1/0", rslt_valid, rslt);
    end
    tick();
    checks++;
    if (snp_ready !== 1'b1 || upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_i_done: ready=%b upd=%b required 1/0", snp_ready, upd_valid);
    end
  endtask

  task automatic test_rwim_m();
    set_lookup(1'b1, 1'b1, 3'd2, 2'd0);
    issue(3'd4, 32'h1234_5680);
    checks++;
    if (lk_req !== 1'b1 || lk_set !== 15'h515A || lk_tag !== 11'h091) begin
      errors++;
      $display("FAIL rwim_lookup: req=%b set=%h tag=%h required 1/515a/091", lk_req, lk_set, lk_tag);
    end
    tick();
    checks++;
    if (rslt_valid !== 1'b1 || rslt !== 2'd2) begin
      errors++;
      $display("FAIL rwim_rslt: vld=%b rslt=%0d required 1/2", rslt_valid, rslt);
    end
    tick();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (wb_req !== 1'b1 || wb_addr !== 32'h1234_5680 || upd_valid !== 1'b0) begin
        errors++;
        $display("FAIL rwim_wb cyc%0d: req=%b addr=%h upd=%b required 1/12345680/0",
                 i, wb_req, wb_addr, upd_valid);
      end
      if (i == 6) wb_done = 1'b1;
      tick();
      wb_done = 1'b0;
    end
    checks++;
    if (upd_valid !== 1'b1 || upd_state !== 2'd3 || upd_way !== 3'd2 ||
        upd_set !== 15'h515A || wb_req !== 1'b0) begin
      errors++;
      $display("FAIL rwim_upd: vld=%b st=%0d way=%0d set=%h wb=%b required 1/3/2/515a/0",
               upd_valid, upd_state, upd_way, upd_set, wb_req);
    end
    tick();
    checks++;
    if (snp_ready !== 1'b1) begin
      errors++;
      $display("FAIL rwim_done: ready=%b required 1", snp_ready);
    end
  endtask

  task automatic test_inv_e();
    set_lookup(1'b1, 1'b1, 3'd1, 2'd1);
    issue(3'd3, 32'h0000_0080);
    tick();
    checks++;
    if (rslt_valid !== 1'b1 || rslt !== 2'd1 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL inv_e_rslt: vld=%b rslt=%0d perr=%b required 1/1/1", rslt_valid, rslt, proto_err);
    end
    tick();
    checks++;
    if (upd_valid !== 1'b1 || upd_state !== 2'd3 || upd_set !== 15'h0002 ||
        upd_way !== 3'd1 || proto_err !== 1'b0 || wb_req !== 1'b0) begin
      errors++;
      $display("FAIL inv_e_upd: vld=%b st=%0d set=%h way=%0d perr=%b wb=%b required 1/3/0002/1/0/0",
               upd_valid, upd_state, upd_set, upd_way, proto_err, wb_req);
    end
    tick();
  endtask

  task automatic test_inv_miss_stall();
    set_lookup(1'b0, 1'b0, 3'd0, 2'd3);
    issue(3'd3, 32'hFFE0_0FC0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lk_req !== 1'b1 || lk_set !== 15'h003F || lk_tag !== 11'h7FF || rslt_valid !== 1'b0) begin
        errors++;
        $display("FAIL inv_stall cyc%0d: req=%b set=%h tag=%h rv=%b required 1/003f/7ff/0",
                 i, lk_req, lk_set, lk_tag, rslt_valid);
      end
      tick();
    end
    lk_ack = 1'b1;
    tick();
    checks++;
    if (rslt_valid !== 1'b1 || rslt !== 2'd0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL inv_miss_rslt: vld=%b rslt=%0d perr=%b required 1/0/0", rslt_valid, rslt, proto_err);
    end
    tick();
    checks++;
    if (snp_ready !== 1'b1 || upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL inv_miss_done: ready=%b upd=%b required 1/0", snp_ready, upd_valid);
    end
  endtask

  task automatic test_write();
    set_lookup(1'b1, 1'b1, 3'd6, 2'd0);
    issue(3'd2, 32'h0ABC_DE40);
    checks++;
    if (lk_req !== 1'b0 || rslt_valid !== 1'b1 || rslt !== 2'd0) begin
      errors++;
      $display("FAIL write_rslt: lkreq=%b vld=%b rslt=%0d required 0/1/0", lk_req, rslt_valid, rslt);
    end
    tick();
    checks++;
    if (snp_ready !== 1'b1 || others !== '0) begin
      errors++;
      $display("FAIL write_done: ready=%b others=%h required 1/0", snp_ready, others);
    end
  endtask

  task automatic test_noop();
    set_lookup(1'b1, 1'b1, 3'd1, 2'd0);
    issue(3'd0, 32'h0000_0040);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (snp_ready !== 1'b1 || others !== '0) begin
        errors++;
        $display("FAIL noop cyc%0d: ready=%b others=%h required 1/0", i, snp_ready, others);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_wb();
    set_lookup(1'b1, 1'b1, 3'd2, 2'd0);
    issue(3'd4, 32'h1234_5680);
    tick();
    tick();
    checks++;
    if (wb_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_wb_pre: wb_req=%b required 1", wb_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wb_req !== 1'b0 || snp_ready !== 1'b1 || others !== '0) begin
      errors++;
      $display("FAIL rst_wb_drop: wb=%b ready=%b others=%h required 0/1/0", wb_req, snp_ready, others);
    end
    tick();
    rst_n = 1'b1;
    wb_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (snp_ready !== 1'b1 || upd_valid !== 1'b0 || wb_req !== 1'b0) begin
        errors++;
        $display("FAIL rst_wb_after cyc%0d: ready=%b upd=%b wb=%b required 1/0/0",
                 i, snp_ready, upd_valid, wb_req);
      end
      tick();
    end
    wb_done = 1'b0;
    test_read_hit_e();
  endtask

  initial begin
    rst_n     = 1'b0;
    snp_valid = 1'b0;
    snp_op    = 3'd0;
    snp_addr  = 32'h0;
    lk_ack    = 1'b0;
    lk_hit    = 1'b0;
    lk_way    = 3'd0;
    lk_state  = 2'd3;
    wb_done   = 1'b0;
    #1;
    test_reset();
    test_read_hit_e();
    test_read_hit_s();
    test_read_stale_i();
    test_rwim_m();
    test_inv_e();
    test_inv_miss_stall();
    test_write();
    test_noop();
    test_reset_in_wb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
